// File: rtl/multimaster_arbiter_pkg.sv
// Shared types and constants for the multi-master bus arbiter.
package multimaster_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   localparam int unsigned MODE_FIXED = 0;
   localparam int unsigned MODE_RR    = 1;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational priority search over a request vector starting at a given index, with wrap.
module arb_priority_pick
   import multimaster_arbiter_pkg::*;
#(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] cand;

   // First set request at or after start, wrapping at N.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IW'((32'(start) + i) % N);
         if (!valid && req[cand]) begin
            valid        = 1'b1;
            idx          = cand;
            onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multimaster_arbiter.sv
// Multi-master arbiter for a single shared bus: fixed-priority or round-robin
// grant, optional lock across acks, and a saturating ack-wait timeout.
module multimaster_arbiter
   import multimaster_arbiter_pkg::*;
#(
   parameter int unsigned NMASTERS = 3,
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 8,
   parameter int unsigned MODE     = 0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic [NMASTERS-1:0]    i_m_cs,
   input  logic [NMASTERS-1:0]    i_m_we,
   input  logic [NMASTERS-1:0]    i_m_lock,
   input  logic [NMASTERS*AW-1:0] i_m_addr,
   input  logic [NMASTERS*DW-1:0] i_m_dat,
   output logic [NMASTERS-1:0]    o_m_ack,
   output logic [NMASTERS-1:0]    o_m_err,
   output logic [NMASTERS-1:0]    o_grant,
   output logic [AW-1:0]          o_addr,
   output logic [DW-1:0]          o_dat,
   output logic                   o_we,
   output logic                   o_cs,
   input  logic                   i_ack,
   output logic                   o_timeout
);

   localparam int unsigned IW = $clog2(NMASTERS);
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW:0]   TO_LIM  = (CW+1)'(TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [NMASTERS-1:0] grant_q, grant_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic [NMASTERS-1:0] pick_onehot;
   logic [IW-1:0]       pick_idx;
   logic [IW-1:0]       pick_start;
   logic                pick_valid;

   logic                active;
   logic                owner_cs;
   logic                ack_hit;
   logic                timeout_hit;
   logic                timeout_fire;

   logic [AW-1:0]       m_addr [NMASTERS];
   logic [DW-1:0]       m_dat  [NMASTERS];

   for (genvar g = 0; g < NMASTERS; g++) begin : g_unpack
      assign m_addr[g] = i_m_addr[g*AW +: AW];
      assign m_dat[g]  = i_m_dat[g*DW +: DW];
   end

   assign pick_start = (MODE == MODE_RR) ? ptr_q : '0;

   arb_priority_pick #(.N(NMASTERS)) u_pick (
      .req    (i_m_cs),
      .start  (pick_start),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // Reset gates the live bus so nothing is acked or errored during a reset cycle.
   assign active   = (state_q == OWNED) && i_reset_n;
   assign owner_cs = i_m_cs[owner_q];
   assign ack_hit  = active && owner_cs && i_ack;

   // The current cycle counts toward the limit; an ack on the same cycle wins.
   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT != 0) begin
         timeout_hit = ((CW+1)'(cnt_q) + (CW+1)'(1)) >= TO_LIM;
      end
   end

   assign timeout_fire = active && owner_cs && !i_ack && timeout_hit;

   assign o_grant   = grant_q;
   assign o_cs      = active && owner_cs;
   assign o_we      = active && i_m_we[owner_q];
   assign o_addr    = active ? m_addr[owner_q] : '0;
   assign o_dat     = active ? m_dat[owner_q]  : '0;
   assign o_m_ack   = ack_hit      ? grant_q : '0;
   assign o_m_err   = timeout_fire ? grant_q : '0;
   assign o_timeout = timeout_fire;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_valid) begin
               state_d = OWNED;
               owner_d = pick_idx;
               grant_d = pick_onehot;
               ptr_d   = (32'(pick_idx) == NMASTERS - 1) ? '0 : pick_idx + IW'(1);
            end
         end
         OWNED: begin
            if (!owner_cs || (i_ack && !i_m_lock[owner_q]) || (!i_ack && timeout_hit)) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (i_ack) begin
               cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multimaster_arbiter.sv
// Bench: fixed-priority and round-robin arbiters share stimulus and are each
// compared every cycle against a transaction-level model of the bus owner.
module tb_multimaster_arbiter;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    cs, we, lock;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] dat;
   logic            ack;

   logic [N-1:0]  f_ack, f_err, f_grant, r_ack, r_err, r_grant;
   logic [AW-1:0] f_addr, r_addr;
   logic [DW-1:0] f_dat, r_dat;
   logic          f_we, f_cs, f_to, r_we, r_cs, r_to;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per arbiter (0 = fixed, 1 = round-robin): owner (-1 idle),
   // next round-robin start, and completed OWNED cycles without an ack.
   int m_owner [2];
   int m_ptr   [2];
   int m_wait  [2];

   logic [N-1:0] seen_ack [2];
   logic [N-1:0] seen_err [2];
   logic         seen_to  [2];

   logic [N-1:0] rr_exp [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};

   always #5 clk = ~clk;

   multimaster_arbiter #(.NMASTERS(N), .AW(AW), .DW(DW), .MODE(0), .TIMEOUT(TO)) u_fixed (
      .i_clk(clk), .i_reset_n(rst_n), .i_m_cs(cs), .i_m_we(we), .i_m_lock(lock),
      .i_m_addr(addr), .i_m_dat(dat), .o_m_ack(f_ack), .o_m_err(f_err), .o_grant(f_grant),
      .o_addr(f_addr), .o_dat(f_dat), .o_we(f_we), .o_cs(f_cs), .i_ack(ack), .o_timeout(f_to)
   );

   multimaster_arbiter #(.NMASTERS(N), .AW(AW), .DW(DW), .MODE(1), .TIMEOUT(TO)) u_rr (
      .i_clk(clk), .i_reset_n(rst_n), .i_m_cs(cs), .i_m_we(we), .i_m_lock(lock),
      .i_m_addr(addr), .i_m_dat(dat), .o_m_ack(r_ack), .o_m_err(r_err), .o_grant(r_grant),
      .o_addr(r_addr), .o_dat(r_dat), .o_we(r_we), .o_cs(r_cs), .i_ack(ack), .o_timeout(r_to)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected bus view for the current cycle, from the model owner and live inputs.
   task automatic check_dut(input int d);
      string         p;
      int            o;
      logic [N-1:0]  sh;
      logic [N-1:0]  g_grant, g_ack, g_err, e_grant, e_ack, e_err;
      logic          g_cs, g_we, g_to, e_cs, e_we, e_to;
      logic [AW-1:0] g_addr, e_addr;
      logic [DW-1:0] g_dat, e_dat;
      if (d == 0) begin
         p = "fix"; g_grant = f_grant; g_ack = f_ack; g_err = f_err;
         g_cs = f_cs; g_we = f_we; g_to = f_to; g_addr = f_addr; g_dat = f_dat;
      end else begin
         p = "rr"; g_grant = r_grant; g_ack = r_ack; g_err = r_err;
         g_cs = r_cs; g_we = r_we; g_to = r_to; g_addr = r_addr; g_dat = r_dat;
      end
      o = m_owner[d];
      e_grant = '0; e_ack = '0; e_err = '0; e_cs = 1'b0; e_we = 1'b0; e_to = 1'b0;
      e_addr = '0; e_dat = '0;
      if (o >= 0) e_grant = N'(1) << o;
      if (o >= 0 && rst_n) begin
         sh = cs >> o;   e_cs = sh[0];
         sh = we >> o;   e_we = sh[0];
         e_addr = AW'(addr >> (o * AW));
         e_dat  = DW'(dat >> (o * DW));
         if (e_cs && ack) e_ack = e_grant;
         else if (e_cs && (m_wait[d] + 1 >= TO)) begin
            e_err = e_grant;
            e_to  = 1'b1;
         end
      end
      check({p, "_grant"},   64'(g_grant), 64'(e_grant));
      check({p, "_cs"},      64'(g_cs),    64'(e_cs));
      check({p, "_we"},      64'(g_we),    64'(e_we));
      check({p, "_addr"},    64'(g_addr),  64'(e_addr));
      check({p, "_dat"},     64'(g_dat),   64'(e_dat));
      check({p, "_ack"},     64'(g_ack),   64'(e_ack));
      check({p, "_err"},     64'(g_err),   64'(e_err));
      check({p, "_timeout"}, 64'(g_to),    64'(e_to));
      seen_ack[d] = g_ack;
      seen_err[d] = g_err;
      seen_to[d]  = g_to;
   endtask

   // Advance the model by one clock edge.
   task automatic model_step(input int d);
      int           o, start, j;
      logic [N-1:0] sh;
      o = m_owner[d];
      if (!rst_n) begin
         m_owner[d] = -1; m_ptr[d] = 0; m_wait[d] = 0;
      end else if (o < 0) begin
         start = (d == 1) ? m_ptr[d] : 0;
         for (int i = 0; i < N; i++) begin
            j  = (start + i) % N;
            sh = cs >> j;
            if (sh[0]) begin
               m_owner[d] = j; m_ptr[d] = (j + 1) % N; m_wait[d] = 0;
               break;
            end
         end
      end else begin
         sh = cs >> o;
         if (!sh[0]) m_owner[d] = -1;
         else if (ack) begin
            sh = lock >> o;
            if (sh[0]) m_wait[d] = 0;
            else m_owner[d] = -1;
         end
         else if (m_wait[d] + 1 >= TO) m_owner[d] = -1;
         else m_wait[d]++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_dut(0);
      check_dut(1);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      if ($urandom_range(0, 9) < 3) cs = N'($urandom);
      we    = N'($urandom);
      lock  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      addr  = (N*AW)'({$urandom, $urandom});
      dat   = (N*DW)'($urandom);
      ack   = ($urandom_range(0, 9) < 4);
      rst_n = ($urandom_range(0, 99) != 0);
   endtask

   initial begin
      rst_n = 1'b0; cs = '0; we = '0; lock = '0; addr = '0; dat = '0; ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1; m_ptr[i] = 0; m_wait[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      ack = 1'b1;
      step();
      ack = 1'b0;
      rst_n = 1'b1;

      // Masters 0 and 2 together: 0 first, 2 two cycles after its ack.
      addr = 48'h3333_2222_1111; dat = 24'hCC_BB_AA; we = 3'b101;
      cs = 3'b101; step();
      check("fixed_first", 64'(f_grant), 64'(3'b001));
      ack = 1'b1; step();
      check("fixed_ack_idle", 64'(f_grant), 64'(3'b000));
      ack = 1'b0; cs = 3'b100; step();
      check("fixed_second", 64'(f_grant), 64'(3'b100));
      ack = 1'b1; step();
      ack = 1'b0; cs = 3'b000; step();

      // Round-robin rotation with every master requesting and acked each cycle.
      cs = 3'b111; ack = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step();
         check("rr_sequence", 64'(r_grant), 64'(rr_exp[k]));
      end
      cs = 3'b000; ack = 1'b0; step();

      // Locked ownership through three acks, then release to the waiting master.
      cs = 3'b010; step();
      check("lock_grant", 64'(f_grant), 64'(3'b010));
      cs = 3'b011; lock = 3'b010; ack = 1'b1;
      repeat (3) begin
         step();
         check("lock_hold", 64'(f_grant), 64'(3'b010));
      end
      lock = 3'b000; step();
      check("lock_release", 64'(f_grant), 64'(3'b000));
      cs = 3'b001; ack = 1'b0; step();
      check("lock_next_fix", 64'(f_grant), 64'(3'b001));
      check("lock_next_rr", 64'(r_grant), 64'(3'b001));

      // No ack: error and timeout pulse on the 4th owned cycle.
      for (int k = 1; k <= 4; k++) begin
         step();
         check("to_pulse", 64'(seen_to[0]), 64'(k == 4));
         check("to_err", 64'(seen_err[1]), (k == 4) ? 64'(3'b001) : 64'(0));
      end
      check("to_idle", 64'(f_grant), 64'(3'b000));

      // Reset while owned with ack high.
      step();
      check("rst_pre", 64'(f_grant), 64'(3'b001));
      rst_n = 1'b0; ack = 1'b1; step();
      check("rst_noack", 64'(seen_ack[0]), 64'(0));
      check("rst_grant", 64'(f_grant), 64'(3'b000));
      check("rst_cs", 64'(f_cs), 64'(0));
      rst_n = 1'b1; ack = 1'b0; cs = 3'b000; step();

      // Owner drops cs after two owned cycles: abort, then next requester.
      cs = 3'b011; step();
      repeat (2) step();
      cs = 3'b010; step();
      check("abort_idle", 64'(f_grant), 64'(3'b000));
      check("abort_noerr", 64'(seen_err[0]), 64'(0));
      check("abort_noack", 64'(seen_ack[0]), 64'(0));
      step();
      check("abort_next_fix", 64'(f_grant), 64'(3'b010));
      check("abort_next_rr", 64'(r_grant), 64'(3'b010));

      for (int k = 0; k < 1500; k++) begin
         rand_inputs();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
